// File: rtl/branch_pkg.sv
// ---------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the EX-stage branch/jump resolution controller:
//   - RISC-V opcode constants for conditional branches, JAL and JALR
//   - funct3 constants selecting the branch comparison
//   - br_state_t, the resolution controller state encoding
// ---------------------------------------------------------------------------
package branch_pkg;

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT     = 2'd1,
      REDIRECT = 2'd2,
      FLUSH    = 2'd3
   } br_state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// ---------------------------------------------------------------------------
// branch_cond_eval
// Purely combinational decode of a {funct3, opcode} pair plus evaluation of
// the branch condition from the ALU compare flags of rs1-rs2.
// Ports:
//   i_opfunct    {funct3, opcode[6:0]}
//   i_z/n/v/c    zero, negative, overflow, carry (c=1 means no borrow)
//   o_is_branch  conditional branch encoding
//   o_is_jump    JAL or JALR
//   o_illegal    anything else
//   o_taken      condition result (always 1 for jumps)
// ---------------------------------------------------------------------------
module branch_cond_eval
   import branch_pkg::*;
(
   input  logic [9:0] i_opfunct,
   input  logic       i_z,
   input  logic       i_n,
   input  logic       i_v,
   input  logic       i_c,
   output logic       o_is_branch,
   output logic       o_is_jump,
   output logic       o_illegal,
   output logic       o_taken
);

   logic [2:0] w_funct3;
   logic [6:0] w_opcode;

   assign w_funct3 = i_opfunct[9:7];
   assign w_opcode = i_opfunct[6:0];

   // Classify the instruction and evaluate its condition. Signed less-than
   // is n^v; unsigned less-than is a borrow, i.e. !c.
   always_comb begin
      o_is_branch = 1'b0;
      o_is_jump   = 1'b0;
      o_illegal   = 1'b0;
      o_taken     = 1'b0;
      case (w_opcode)
         OP_BRANCH: begin
            o_is_branch = 1'b1;
            case (w_funct3)
               F3_BEQ:  o_taken = i_z;
               F3_BNE:  o_taken = ~i_z;
               F3_BLT:  o_taken = i_n ^ i_v;
               F3_BGE:  o_taken = ~(i_n ^ i_v);
               F3_BLTU: o_taken = ~i_c;
               F3_BGEU: o_taken = i_c;
               default: begin
                  o_is_branch = 1'b0;
                  o_illegal   = 1'b1;
               end
            endcase
         end
         OP_JAL: begin
            o_is_jump = 1'b1;
            o_taken   = 1'b1;
         end
         OP_JALR: begin
            if (w_funct3 == 3'b000) begin
               o_is_jump = 1'b1;
               o_taken   = 1'b1;
            end else begin
               o_illegal = 1'b1;
            end
         end
         default: o_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// ---------------------------------------------------------------------------
// branch_resolve_ctrl
// EX-stage sequencing controller for branch/jump resolution. Accepts one
// branch or jump at a time, waits for ALU flags on conditional branches,
// drives a one-cycle PC redirect and flushes IF/ID for FLUSH_CYCLES more
// cycles. Keeps saturating resolved/taken performance counters.
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset
//   i_br_valid/o_br_ready   instruction handshake (ready only in IDLE)
//   i_br_opfunct, i_br_target  {funct3, opcode}, computed target PC
//   i_flags_valid, i_flag_* ALU compare flags of rs1-rs2
//   i_kill                  abort in-flight resolution
//   o_stall_if, o_flush_ifid  front-end hold / squash
//   o_redirect_valid/pc     PC load strobe and target
//   o_illegal_br            pulse after an unsupported opfunct is accepted
//   o_cnt_resolved/taken    saturating perf counters
// ---------------------------------------------------------------------------
module branch_resolve_ctrl
   import branch_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
)(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_br_valid,
   output logic             o_br_ready,
   input  logic [9:0]       i_br_opfunct,
   input  logic [31:0]      i_br_target,
   input  logic             i_flags_valid,
   input  logic             i_flag_z,
   input  logic             i_flag_n,
   input  logic             i_flag_v,
   input  logic             i_flag_c,
   input  logic             i_kill,
   output logic             o_stall_if,
   output logic             o_flush_ifid,
   output logic             o_redirect_valid,
   output logic [31:0]      o_redirect_pc,
   output logic             o_illegal_br,
   output logic [CNT_W-1:0] o_cnt_resolved,
   output logic [CNT_W-1:0] o_cnt_taken
);

   localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FC_W-1:0] FC_LOAD = FC_W'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

   br_state_t        r_state;
   br_state_t        w_next_state;
   logic [9:0]       r_opfunct;
   logic [31:0]      r_target;
   logic [FC_W-1:0]  r_flush_cnt;
   logic             r_illegal;
   logic [CNT_W-1:0] r_cnt_resolved;
   logic [CNT_W-1:0] r_cnt_taken;

   logic [9:0]       w_eval_opfunct;
   logic             w_is_branch;
   logic             w_is_jump;
   logic             w_illegal;
   logic             w_taken;
   logic             w_accept;
   logic             w_inc_resolved;
   logic             w_inc_taken;
   logic             w_illegal_next;

   // One evaluator serves both phases: in IDLE it classifies the incoming
   // instruction, afterwards it evaluates the latched one against the flags.
   assign w_eval_opfunct = (r_state == IDLE) ? i_br_opfunct : r_opfunct;

   branch_cond_eval u_cond_eval (
      .i_opfunct   (w_eval_opfunct),
      .i_z         (i_flag_z),
      .i_n         (i_flag_n),
      .i_v         (i_flag_v),
      .i_c         (i_flag_c),
      .o_is_branch (w_is_branch),
      .o_is_jump   (w_is_jump),
      .o_illegal   (w_illegal),
      .o_taken     (w_taken)
   );

   // Next-state and counting decisions. Kill forces IDLE and suppresses
   // acceptance, evaluation and counting in the same cycle.
   always_comb begin
      w_next_state   = r_state;
      w_accept       = 1'b0;
      w_inc_resolved = 1'b0;
      w_inc_taken    = 1'b0;
      w_illegal_next = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_br_valid && !i_kill) begin
               w_accept = 1'b1;
               if (w_is_jump) begin
                  w_next_state   = REDIRECT;
                  w_inc_resolved = 1'b1;
                  w_inc_taken    = 1'b1;
               end else if (w_is_branch) begin
                  w_next_state = WAIT;
               end else begin
                  w_illegal_next = w_illegal;
               end
            end
         end
         WAIT: begin
            if (i_flags_valid && !i_kill) begin
               w_inc_resolved = 1'b1;
               if (w_taken) begin
                  w_next_state = REDIRECT;
                  w_inc_taken  = 1'b1;
               end else begin
                  w_next_state = IDLE;
               end
            end
         end
         REDIRECT: w_next_state = (FLUSH_CYCLES > 0) ? FLUSH : IDLE;
         FLUSH: begin
            if (r_flush_cnt == '0) begin
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
      if (i_kill) begin
         w_next_state = IDLE;
      end
   end

   // State, latched instruction, flush down-counter and illegal pulse.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= IDLE;
         r_opfunct   <= '0;
         r_target    <= '0;
         r_flush_cnt <= '0;
         r_illegal   <= 1'b0;
      end else begin
         r_state   <= w_next_state;
         r_illegal <= w_illegal_next;
         if (w_accept) begin
            r_opfunct <= i_br_opfunct;
            r_target  <= i_br_target;
         end
         if (r_state == REDIRECT) begin
            r_flush_cnt <= FC_LOAD;
         end else if (r_state == FLUSH && r_flush_cnt != '0) begin
            r_flush_cnt <= r_flush_cnt - FC_W'(1);
         end
      end
   end

   // Performance counters stick at all-ones instead of wrapping.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt_resolved <= '0;
         r_cnt_taken    <= '0;
      end else begin
         if (w_inc_resolved && r_cnt_resolved != '1) begin
            r_cnt_resolved <= r_cnt_resolved + CNT_W'(1);
         end
         if (w_inc_taken && r_cnt_taken != '1) begin
            r_cnt_taken <= r_cnt_taken + CNT_W'(1);
         end
      end
   end

   assign o_br_ready       = (r_state == IDLE);
   assign o_stall_if       = (r_state == WAIT);
   assign o_redirect_valid = (r_state == REDIRECT);
   assign o_flush_ifid     = (r_state == REDIRECT) || (r_state == FLUSH);
   assign o_redirect_pc    = r_target;
   assign o_illegal_br     = r_illegal;
   assign o_cnt_resolved   = r_cnt_resolved;
   assign o_cnt_taken      = r_cnt_taken;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_ctrl
// Scoreboarded bench for branch_resolve_ctrl. The stimulus task predicts each
// redirect / illegal pulse from the instruction-level rules and queues it;
// an independent monitor pops and compares whenever the DUT shows one.
// A second instance (no flush cycles, 3-bit counters) covers saturation
// and the zero-flush return path.
// ---------------------------------------------------------------------------
module tb_branch_resolve_ctrl;

   localparam int F   = 2;
   localparam int CW  = 16;
   localparam int F2  = 0;
   localparam int CW2 = 3;

   typedef struct {
      bit          isIllegal;
      logic [31:0] pc;
      int          res;
      int          tak;
   } ev_t;

   logic clk = 1'b0;
   logic rstN;

   logic          brValid, brReady, flagsValid, flagZ, flagN, flagV, flagC, kill;
   logic [9:0]    brOpfunct;
   logic [31:0]   brTarget, redirectPc;
   logic          stallIf, flushIfid, redirectValid, illegalBr;
   logic [CW-1:0] cntResolved, cntTaken;

   logic           brValid2, brReady2, flagsValid2, flagZ2, kill2;
   logic [9:0]     brOpfunct2;
   logic [31:0]    brTarget2, redirectPc2;
   logic           stallIf2, flushIfid2, redirectValid2, illegalBr2;
   logic [CW2-1:0] cntResolved2, cntTaken2;

   int  total = 0;
   int  bad   = 0;
   int  mRes  = 0;
   int  mTak  = 0;
   int  m2Res = 0;
   int  m2Tak = 0;
   ev_t sbq[$];

   always #5 clk = ~clk;

   branch_resolve_ctrl #(.FLUSH_CYCLES(F), .CNT_W(CW)) dut (
      .i_clk(clk), .i_rst_n(rstN), .i_br_valid(brValid), .o_br_ready(brReady),
      .i_br_opfunct(brOpfunct), .i_br_target(brTarget), .i_flags_valid(flagsValid),
      .i_flag_z(flagZ), .i_flag_n(flagN), .i_flag_v(flagV), .i_flag_c(flagC),
      .i_kill(kill), .o_stall_if(stallIf), .o_flush_ifid(flushIfid),
      .o_redirect_valid(redirectValid), .o_redirect_pc(redirectPc),
      .o_illegal_br(illegalBr), .o_cnt_resolved(cntResolved), .o_cnt_taken(cntTaken)
   );

   branch_resolve_ctrl #(.FLUSH_CYCLES(F2), .CNT_W(CW2)) dut2 (
      .i_clk(clk), .i_rst_n(rstN), .i_br_valid(brValid2), .o_br_ready(brReady2),
      .i_br_opfunct(brOpfunct2), .i_br_target(brTarget2), .i_flags_valid(flagsValid2),
      .i_flag_z(flagZ2), .i_flag_n(1'b0), .i_flag_v(1'b0), .i_flag_c(1'b0),
      .i_kill(kill2), .o_stall_if(stallIf2), .o_flush_ifid(flushIfid2),
      .o_redirect_valid(redirectValid2), .o_redirect_pc(redirectPc2),
      .o_illegal_br(illegalBr2), .o_cnt_resolved(cntResolved2), .o_cnt_taken(cntTaken2)
   );

   // Reference model: 0 = illegal, 1 = conditional branch, 2 = jump.
   function automatic int modelKind(input logic [9:0] op);
      if (op[6:0] == 7'b1101111) return 2;
      if (op == 10'b000_1100111) return 2;
      if (op[6:0] == 7'b1100011 && op[9:7] != 3'b010 && op[9:7] != 3'b011) return 1;
      return 0;
   endfunction

   // Branch outcome from the compare view of rs1-rs2.
   function automatic logic modelTaken(input logic [2:0] f3, input logic z, n, v, c);
      logic eq, lt, ltu;
      eq  = z;
      lt  = n ^ v;
      ltu = !c;
      case (f3)
         3'd0:    return eq;
         3'd1:    return !eq;
         3'd4:    return lt;
         3'd5:    return !lt;
         3'd6:    return ltu;
         default: return !ltu;
      endcase
   endfunction

   function automatic int satInc(input int x, input int w);
      return (x >= (1 << w) - 1) ? x : x + 1;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every redirect or illegal pulse must match the oldest prediction.
   always @(negedge clk) begin
      ev_t ev;
      if (rstN && (redirectValid || illegalBr)) begin
         if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpectedEvent: got redirect=%0b illegal=%0b expected none",
                     redirectValid, illegalBr);
         end else begin
            ev = sbq.pop_front();
            checkOutput("eventIsIllegal", {31'd0, illegalBr}, {31'd0, ev.isIllegal});
            checkOutput("eventIsRedirect", {31'd0, redirectValid}, {31'd0, !ev.isIllegal});
            if (!ev.isIllegal) checkOutput("redirectPc", redirectPc, ev.pc);
            checkOutput("eventCntResolved", 32'(cntResolved), ev.res);
            checkOutput("eventCntTaken", 32'(cntTaken), ev.tak);
         end
      end
   end

   // Issue one instruction at a negedge in IDLE, deliver flags k cycles after
   // acceptance (branches only), and check latency, stall/flush span, counters.
   task automatic applyStimulus(input logic [9:0] op, input logic [31:0] tgt, input int k,
                                input logic z, n, v, c, input logic killW);
      int   kind, expLat, expStall, expFlush, lat, stallN, flushN;
      logic tk;
      ev_t  ev;
      for (int w = 0; w < 40 && !brReady; w++) @(negedge clk);
      checkOutput("readyBeforeIssue", {31'd0, brReady}, 32'd1);
      kind     = modelKind(op);
      tk       = modelTaken(op[9:7], z, n, v, c);
      expStall = (kind == 1) ? k : 0;
      expFlush = 0;
      expLat   = 1;
      if (kind == 0) begin
         ev = '{1'b1, 32'd0, mRes, mTak};
         sbq.push_back(ev);
      end else if (kind == 2) begin
         mRes = satInc(mRes, CW);
         mTak = satInc(mTak, CW);
         ev = '{1'b0, tgt, mRes, mTak};
         sbq.push_back(ev);
         expLat   = 2 + F;
         expFlush = F + 1;
      end else if (killW) begin
         expLat = k + 1;
      end else begin
         mRes = satInc(mRes, CW);
         expLat = k + 1;
         if (tk) begin
            mTak = satInc(mTak, CW);
            ev = '{1'b0, tgt, mRes, mTak};
            sbq.push_back(ev);
            expLat   = k + 2 + F;
            expFlush = F + 1;
         end
      end
      brValid    = 1'b1;
      brOpfunct  = op;
      brTarget   = tgt;
      kill       = 1'b0;
      flagsValid = 1'($urandom % 2);
      {flagZ, flagN, flagV, flagC} = 4'($urandom);
      @(posedge clk);
      #1;
      brValid   = 1'b0;
      brOpfunct = 10'($urandom);
      lat = 0; stallN = 0; flushN = 0;
      for (int j = 1; j <= k + F + 8; j++) begin
         if (kind == 1 && j == k) begin
            flagsValid = 1'b1;
            {flagZ, flagN, flagV, flagC} = {z, n, v, c};
            kill = killW;
         end else if (kind == 1 && j < k) begin
            flagsValid = 1'b0;
            kill = 1'b0;
         end else begin
            flagsValid = 1'($urandom % 2);
            {flagZ, flagN, flagV, flagC} = 4'($urandom);
            kill = 1'b0;
         end
         @(negedge clk);
         if (stallIf) stallN++;
         if (flushIfid) flushN++;
         if (brReady) begin
            lat = j;
            break;
         end
         @(posedge clk);
         #1;
      end
      flagsValid = 1'b0;
      kill       = 1'b0;
      checkOutput("latencyToReady", lat, expLat);
      checkOutput("stallCycles", stallN, expStall);
      checkOutput("flushCycles", flushN, expFlush);
      checkOutput("cntResolved", 32'(cntResolved), mRes);
      checkOutput("cntTaken", 32'(cntTaken), mTak);
   endtask

   // Second instance: accept, present flags in the next cycle, wait for IDLE.
   task automatic issue2(input logic [9:0] op, input logic z);
      @(negedge clk);
      brValid2   = 1'b1;
      brOpfunct2 = op;
      brTarget2  = $urandom;
      @(posedge clk);
      #1;
      brValid2    = 1'b0;
      flagsValid2 = 1'b1;
      flagZ2      = z;
      @(posedge clk);
      #1;
      flagsValid2 = 1'b0;
      for (int i = 0; i < 10 && !brReady2; i++) @(negedge clk);
      if (modelKind(op) == 2 || (modelKind(op) == 1 && modelTaken(op[9:7], z, 1'b0, 1'b0, 1'b0))) begin
         m2Res = satInc(m2Res, CW2);
         m2Tak = satInc(m2Tak, CW2);
      end else if (modelKind(op) == 1) begin
         m2Res = satInc(m2Res, CW2);
      end
   endtask

   initial begin
      logic [9:0]  opTable [9];
      logic [9:0]  op;
      logic [31:0] tgt2;
      int          idx;
      opTable = '{10'b000_1100011, 10'b001_1100011, 10'b100_1100011, 10'b101_1100011,
                  10'b110_1100011, 10'b111_1100011, 10'b011_1101111, 10'b000_1100111,
                  10'b010_1100011};
      rstN = 1'b0;
      brValid = 0; flagsValid = 0; kill = 0; brOpfunct = 0; brTarget = 0;
      {flagZ, flagN, flagV, flagC} = 4'd0;
      brValid2 = 0; flagsValid2 = 0; kill2 = 0; brOpfunct2 = 0; brTarget2 = 0; flagZ2 = 0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("resetBrReady", {31'd0, brReady}, 32'd1);
      checkOutput("resetStallIf", {31'd0, stallIf}, 32'd0);
      checkOutput("resetFlushIfid", {31'd0, flushIfid}, 32'd0);
      checkOutput("resetRedirectValid", {31'd0, redirectValid}, 32'd0);
      checkOutput("resetRedirectPc", redirectPc, 32'd0);
      checkOutput("resetIllegalBr", {31'd0, illegalBr}, 32'd0);
      checkOutput("resetCntResolved", 32'(cntResolved), 32'd0);
      checkOutput("resetCntTaken", 32'(cntTaken), 32'd0);
      @(negedge clk);
      rstN = 1'b1;
      @(negedge clk);

      $display("[TB] directed cases");
      applyStimulus(10'b000_1100011, 32'h0000_0100, 3, 1, 0, 0, 1, 0);
      applyStimulus(10'b100_1100011, 32'h0000_0200, 1, 0, 1, 1, 1, 0);
      applyStimulus(10'b110_1100011, 32'h0000_0300, 2, 0, 0, 0, 0, 0);
      applyStimulus(10'b101_1101111, 32'h8000_0000, 1, 0, 0, 0, 0, 0);
      applyStimulus(10'b000_1100111, 32'h1234_5678, 1, 0, 0, 0, 0, 0);
      applyStimulus(10'b010_1100011, 32'hDEAD_BEE0, 1, 0, 0, 0, 0, 0);
      applyStimulus(10'b000_1100011, 32'h0000_0400, 2, 1, 0, 0, 0, 1);

      // kill together with br_valid in IDLE: nothing is accepted
      brValid = 1'b1; brOpfunct = 10'b000_1101111; brTarget = 32'hCAFE_0000; kill = 1'b1;
      @(posedge clk);
      #1;
      brValid = 1'b0; kill = 1'b0;
      @(negedge clk);
      checkOutput("killIdleReady", {31'd0, brReady}, 32'd1);
      checkOutput("killIdleNoRedirect", {31'd0, redirectValid}, 32'd0);
      checkOutput("killIdleCntResolved", 32'(cntResolved), mRes);

      $display("[TB] random cases");
      for (int t = 0; t < 60; t++) begin
         idx = $urandom_range(0, 10);
         if (idx < 9) op = opTable[idx];
         else op = 10'($urandom);
         applyStimulus(op, $urandom, $urandom_range(1, 4), 1'($urandom), 1'($urandom),
                       1'($urandom), 1'($urandom), ($urandom % 8) == 0);
      end

      // asynchronous reset in the middle of FLUSH
      for (int w = 0; w < 40 && !brReady; w++) @(negedge clk);
      mRes = satInc(mRes, CW);
      mTak = satInc(mTak, CW);
      sbq.push_back('{1'b0, 32'h0000_0500, mRes, mTak});
      brValid = 1'b1; brOpfunct = 10'b000_1101111; brTarget = 32'h0000_0500;
      @(posedge clk);
      #1;
      brValid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("inFlushBeforeReset", {31'd0, flushIfid && !redirectValid}, 32'd1);
      #1;
      rstN = 1'b0;
      #1;
      mRes = 0;
      mTak = 0;
      checkOutput("asyncRstBrReady", {31'd0, brReady}, 32'd1);
      checkOutput("asyncRstFlushIfid", {31'd0, flushIfid}, 32'd0);
      checkOutput("asyncRstStallIf", {31'd0, stallIf}, 32'd0);
      checkOutput("asyncRstRedirectPc", redirectPc, 32'd0);
      checkOutput("asyncRstCntResolved", 32'(cntResolved), 32'd0);
      checkOutput("asyncRstCntTaken", 32'(cntTaken), 32'd0);
      @(negedge clk);
      rstN = 1'b1;
      @(negedge clk);

      $display("[TB] zero-flush and saturation instance");
      for (int i = 0; i < 9; i++) issue2(10'b000_1101111, 1'b0);
      checkOutput("satCntResolved", 32'(cntResolved2), m2Res);
      checkOutput("satCntTaken", 32'(cntTaken2), m2Tak);
      tgt2 = 32'h0000_0700;
      @(negedge clk);
      brValid2 = 1'b1; brOpfunct2 = 10'b000_1100011; brTarget2 = tgt2;
      @(posedge clk);
      #1;
      brValid2 = 1'b0; flagsValid2 = 1'b1; flagZ2 = 1'b1;
      @(negedge clk);
      checkOutput("f0StallInWait", {31'd0, stallIf2}, 32'd1);
      @(posedge clk);
      #1;
      flagsValid2 = 1'b0;
      m2Res = satInc(m2Res, CW2);
      m2Tak = satInc(m2Tak, CW2);
      @(negedge clk);
      checkOutput("f0RedirectValid", {31'd0, redirectValid2}, 32'd1);
      checkOutput("f0RedirectPc", redirectPc2, tgt2);
      @(negedge clk);
      checkOutput("f0ReadyAfterRedirect", {31'd0, brReady2}, 32'd1);
      checkOutput("f0NoFlushAfter", {31'd0, flushIfid2}, 32'd0);
      checkOutput("satAfterTakenResolved", 32'(cntResolved2), m2Res);
      checkOutput("satAfterTakenTaken", 32'(cntTaken2), m2Tak);

      repeat (3) @(negedge clk);
      checkOutput("scoreboardDrained", sbq.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
